// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//   Merges N request-style FIFO read ports into a single valid/ready byte
//   stream tagged with the source channel id. Arbitration is round-robin
//   (starting after the last served channel) or fixed priority (lowest index
//   wins). Grants are bounded bursts of up to MAX_BURST bytes.
//
// Ports
//   i_clk       system clock
//   i_rst_n     asynchronous reset, active-low
//   i_ch_data   per-channel FIFO read data, channel k at [k*DW +: DW]
//   i_ch_ready  per-channel "FIFO not empty"
//   o_ch_req    per-channel pop strobe (one-hot, single-cycle pulse)
//   i_ch_en     per-channel arbitration enable mask
//   o_data      merged output byte
//   o_ch_id     source channel of o_data
//   o_first     o_data is the first byte of a new grant
//   o_valid     output valid
//   i_ready     downstream accepts when o_valid & i_ready
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
  parameter int CHANNELS  = 2,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int ARB_MODE  = 0,
  localparam int ID_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [CHANNELS*DW-1:0] i_ch_data,
  input  logic [CHANNELS-1:0]    i_ch_ready,
  output logic [CHANNELS-1:0]    o_ch_req,
  input  logic [CHANNELS-1:0]    i_ch_en,
  output logic [DW-1:0]          o_data,
  output logic [ID_W-1:0]        o_ch_id,
  output logic                   o_first,
  output logic                   o_valid,
  input  logic                   i_ready
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for an eligible channel
    S_WAIT,   // pop issued, FIFO data arrives this cycle
    S_HOLD    // byte presented downstream, waiting for handshake
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] sel_q, sel_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            first_q, first_d;
  logic            valid_q, valid_d;

  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] ch_req;
  logic [DW-1:0]       ch_data_sel;
  logic [ID_W-1:0]     pick_sel;

  // Winner among eligible channels. Round-robin scans last+1, last+2, ...
  // wrapping at CHANNELS, so the last served channel is considered last.
  function automatic logic [ID_W-1:0] pick(input logic [CHANNELS-1:0] el,
                                           input logic [ID_W-1:0]     last);
    logic [ID_W-1:0] res;
    logic            found;
    int              idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ARB_MODE == 1) begin
        idx = i;
      end else begin
        idx = int'(last) + 1 + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
      end
      if (!found && el[idx]) begin
        res   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    elig        = i_ch_ready & i_ch_en;
    pick_sel    = pick(elig, last_q);
    ch_data_sel = i_ch_data[int'(sel_q)*DW +: DW];
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    data_d      = data_q;
    id_d        = id_q;
    first_d     = first_q;
    valid_d     = valid_q;
    ch_req      = '0;

    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          sel_d            = pick_sel;
          ch_req[pick_sel] = 1'b1;
          burst_cnt_d      = '0;
          state_d          = S_WAIT;
        end
      end
      S_WAIT: begin
        data_d  = ch_data_sel;
        id_d    = sel_q;
        first_d = (burst_cnt_q == '0);
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (i_ready) begin
          burst_cnt_d = burst_cnt_q + BCW'(1);
          valid_d     = 1'b0;
          // Continue the burst with a back-to-back pop when allowed;
          // otherwise hand the grant back for re-arbitration.
          if ((int'(burst_cnt_q) + 1 < MAX_BURST) && elig[sel_q]) begin
            ch_req[sel_q] = 1'b1;
            state_d       = S_WAIT;
          end else begin
            last_d  = sel_q;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      last_q      <= ID_W'(CHANNELS - 1);
      burst_cnt_q <= '0;
      data_q      <= '0;
      id_q        <= '0;
      first_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      data_q      <= data_d;
      id_q        <= id_d;
      first_q     <= first_d;
      valid_q     <= valid_d;
    end
  end

  // The pop strobe is combinational (FIFO latency is one cycle), so it is
  // gated by reset to stay quiet while the FSM is held in reset.
  assign o_ch_req = ch_req & {CHANNELS{i_rst_n}};
  assign o_data   = data_q;
  assign o_ch_id  = id_q;
  assign o_first  = first_q;
  assign o_valid  = valid_q;

endmodule
